// File: rtl/fabric_port_pkg.sv
// Shared fabric-port definitions: flit control-bit positions (as offsets from the
// flit width) and the control-field view used by the ingress FIFO and demultiplexer.
package fabric_port_pkg;

    localparam int FLIT_VALID_POS = 1;
    localparam int FLIT_HEAD_POS  = 2;
    localparam int FLIT_TAIL_POS  = 3;

    typedef struct packed {
        logic valid;
        logic head;
        logic tail;
    } flit_ctrl_t;

endpackage

// File: rtl/flit_ram.sv
// DEPTH x WIDTH flit storage with one synchronous write port and one registered
// read port; the read register clears on reset so the FIFO output starts at zero.
module flit_ram import fabric_port_pkg::*; #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rd_data_r;

    // Storage array write port; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read register holds its value whenever no read is performed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_r <= {WIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/flit_ingress_fifo.sv
// Credit-flow-controlled flit buffer: stores valid flits from the router, serves the
// demultiplexer with one-cycle read latency and returns one credit per freed slot.
module flit_ingress_fifo import fabric_port_pkg::*; #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
) (
    input  logic                     clk_fast,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         i_flit_in,
    output logic                     o_credit_out,
    output logic [WIDTH-1:0]         o_data_out,
    output logic                     o_empty_out,
    input  logic                     i_read_en,
    output logic [$clog2(DEPTH):0]   o_pkt_count,
    output logic                     o_overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_r;
    logic [AW:0]       rd_ptr_r;
    logic [AW:0]       wr_ptr_nxt_s;
    logic [AW:0]       rd_ptr_nxt_s;
    logic [AW:0]       pkt_count_r;
    logic [AW:0]       pkt_count_nxt_s;
    logic [DEPTH-1:0]  tail_r;
    logic              empty_r;
    logic              credit_r;
    logic              overflow_r;

    logic              empty_s;
    logic              full_s;
    logic              flit_valid_s;
    logic              flit_tail_s;
    logic              do_wr_s;
    logic              do_rd_s;
    logic              drop_s;
    logic              pop_tail_s;

    assign flit_valid_s = i_flit_in[WIDTH-FLIT_VALID_POS];
    assign flit_tail_s  = i_flit_in[WIDTH-FLIT_TAIL_POS];

    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);

    // A same-cycle read frees the slot, so a write into a full buffer still lands.
    assign do_rd_s = i_read_en & ~empty_s;
    assign do_wr_s = flit_valid_s & (~full_s | do_rd_s);
    assign drop_s  = flit_valid_s & full_s & ~do_rd_s;

    // Tail bits are shadowed here so the packet count can track pops at the read edge.
    assign pop_tail_s = tail_r[rd_ptr_r[AW-1:0]];

    // Next-state for pointers and packet count.
    always_comb begin
        wr_ptr_nxt_s    = wr_ptr_r;
        rd_ptr_nxt_s    = rd_ptr_r;
        pkt_count_nxt_s = pkt_count_r;
        if (do_wr_s) begin
            wr_ptr_nxt_s = wr_ptr_r + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (do_rd_s) begin
            rd_ptr_nxt_s = rd_ptr_r + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({do_wr_s & flit_tail_s, do_rd_s & pop_tail_s})
            2'b10:   pkt_count_nxt_s = pkt_count_r + {{AW{1'b0}}, 1'b1};
            2'b01:   pkt_count_nxt_s = pkt_count_r - {{AW{1'b0}}, 1'b1};
            default: pkt_count_nxt_s = pkt_count_r;
        endcase
    end

    // Control state registers: pointers, flags, credit pulse and sticky overflow.
    always_ff @(posedge clk_fast or negedge rst) begin
        if (!rst) begin
            wr_ptr_r    <= {(AW+1){1'b0}};
            rd_ptr_r    <= {(AW+1){1'b0}};
            pkt_count_r <= {(AW+1){1'b0}};
            empty_r     <= 1'b1;
            credit_r    <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            pkt_count_r <= pkt_count_nxt_s;
            empty_r     <= (wr_ptr_nxt_s == rd_ptr_nxt_s);
            credit_r    <= do_rd_s;
            overflow_r  <= overflow_r | drop_s;
        end
    end

    // Tail-bit shadow of the flit array.
    always_ff @(posedge clk_fast or negedge rst) begin
        if (!rst) begin
            tail_r <= {DEPTH{1'b0}};
        end else if (do_wr_s) begin
            tail_r[wr_ptr_r[AW-1:0]] <= flit_tail_s;
        end
    end

    flit_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_flit_ram (
        .clk     (clk_fast),
        .rst     (rst),
        .wr_en   (do_wr_s),
        .wr_addr (wr_ptr_r[AW-1:0]),
        .wr_data (i_flit_in),
        .rd_en   (do_rd_s),
        .rd_addr (rd_ptr_r[AW-1:0]),
        .rd_data (o_data_out)
    );

    assign o_credit_out = credit_r;
    assign o_empty_out  = empty_r;
    assign o_pkt_count  = pkt_count_r;
    assign o_overflow   = overflow_r;

endmodule
